// File: rtl/ex_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_stage
// Brief    : EX/MEM pipeline register and single-issue memory request sequencer.
//            Optional macro EXMEM_TIMEOUT_EN aborts requests outstanding TIMEOUT cycles.
// Revision : 1.0
// ============================================================================
module ex_mem_stage #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [15:0] ex_aluout,
    input  logic [15:0] ex_wrdata,
    input  logic        ex_memrd,
    input  logic        ex_memwrt,
    input  logic        ex_regwrt,
    input  logic [2:0]  ex_wrreg,
    input  logic        ex_halt,
    input  logic        flush,
    input  logic        hold_ext,
    input  logic        mem_done,
    output logic [15:0] ALUout,
    output logic [15:0] wrdata,
    output logic        MemRd,
    output logic        MemWrt,
    output logic        mem_valid,
    output logic        mem_regwrt,
    output logic        mem_halt,
    output logic [2:0]  mem_wrreg,
    output logic        stall_up,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
        $error("ex_mem_stage: TIMEOUT must lie in 1..255");
    end

    state_t      r_st;
    logic [15:0] r_aluout;
    logic [15:0] r_wrdata;
    logic        r_rd;
    logic        r_wr;
    logic        r_valid;
    logic        r_regwrt;
    logic        r_halt;
    logic [2:0]  r_wrreg;
    logic        r_err;

    logic        w_advance;
    logic        w_stall;
    logic        w_cap_valid;
    logic        w_cap_mem;
    logic        w_cap_req;
    logic        w_cap_misaligned;
    logic        w_in_req;
    logic        w_timeout;

    assign w_in_req         = (r_st == REQ);
    assign w_cap_valid      = ex_valid & ~flush;
    assign w_cap_mem        = w_cap_valid & (ex_memrd | ex_memwrt);
    assign w_cap_req        = w_cap_mem & ~ex_aluout[0];
    assign w_cap_misaligned = w_cap_mem &  ex_aluout[0];

    // The timeout cycle itself still stalls; the aborted entry stays visible
    // with err set for one cycle before the next capture.
    assign w_stall   = hold_ext | (w_in_req & ~mem_done);
    assign w_advance = ~w_stall;

`ifdef EXMEM_TIMEOUT_EN
    localparam logic [7:0] c_TO_LAST = 8'(TIMEOUT - 1);

    logic [7:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= 8'd0;
        end else if (w_in_req && !mem_done && !w_timeout && !w_advance) begin
            r_cnt <= r_cnt + 8'd1;
        end else begin
            r_cnt <= 8'd0;
        end
    end

    assign w_timeout = w_in_req & ~mem_done & (r_cnt == c_TO_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_st     <= IDLE;
            r_aluout <= 16'd0;
            r_wrdata <= 16'd0;
            r_rd     <= 1'b0;
            r_wr     <= 1'b0;
            r_valid  <= 1'b0;
            r_regwrt <= 1'b0;
            r_halt   <= 1'b0;
            r_wrreg  <= 3'd0;
            r_err    <= 1'b0;
        end else if (w_advance) begin
            r_aluout <= ex_aluout;
            r_wrdata <= ex_wrdata;
            r_wrreg  <= ex_wrreg;
            r_valid  <= w_cap_valid;
            r_rd     <= w_cap_valid & ex_memrd;
            r_wr     <= w_cap_valid & ex_memwrt;
            r_regwrt <= w_cap_valid & ex_regwrt;
            r_halt   <= w_cap_valid & ex_halt;
            r_err    <= w_cap_misaligned;
            r_st     <= w_cap_req ? REQ : IDLE;
        end else if (w_timeout) begin
            r_st     <= IDLE;
            r_err    <= 1'b1;
            r_regwrt <= 1'b0;
        end else if (w_in_req && mem_done) begin
            // Access finished but downstream is holding: park so it is not reissued.
            r_st <= DONE;
        end
    end

    assign ALUout     = r_aluout;
    assign wrdata     = r_wrdata;
    assign MemRd      = w_in_req & r_rd;
    assign MemWrt     = w_in_req & r_wr;
    assign mem_valid  = r_valid;
    assign mem_regwrt = r_regwrt;
    assign mem_halt   = r_halt;
    assign mem_wrreg  = r_wrreg;
    assign stall_up   = w_stall;
    assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_mem_stage
// Brief    : Directed scenarios plus randomized traffic against a transaction model.
// Revision : 1.0
// ============================================================================
module tb_ex_mem_stage;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [15:0] ex_aluout;
    logic [15:0] ex_wrdata;
    logic        ex_memrd;
    logic        ex_memwrt;
    logic        ex_regwrt;
    logic [2:0]  ex_wrreg;
    logic        ex_halt;
    logic        flush;
    logic        hold_ext;
    logic        mem_done;
    logic [15:0] ALUout;
    logic [15:0] wrdata;
    logic        MemRd;
    logic        MemWrt;
    logic        mem_valid;
    logic        mem_regwrt;
    logic        mem_halt;
    logic [2:0]  mem_wrreg;
    logic        stall_up;
    logic        err;

    int nchk  = 0;
    int nfail = 0;

    ex_mem_stage #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_aluout(ex_aluout), .ex_wrdata(ex_wrdata),
        .ex_memrd(ex_memrd), .ex_memwrt(ex_memwrt), .ex_regwrt(ex_regwrt),
        .ex_wrreg(ex_wrreg), .ex_halt(ex_halt), .flush(flush),
        .hold_ext(hold_ext), .mem_done(mem_done),
        .ALUout(ALUout), .wrdata(wrdata), .MemRd(MemRd), .MemWrt(MemWrt),
        .mem_valid(mem_valid), .mem_regwrt(mem_regwrt), .mem_halt(mem_halt),
        .mem_wrreg(mem_wrreg), .stall_up(stall_up), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ex_valid = 1'b0; ex_aluout = 16'd0; ex_wrdata = 16'd0;
        ex_memrd = 1'b0; ex_memwrt = 1'b0; ex_regwrt = 1'b0;
        ex_wrreg = 3'd0; ex_halt = 1'b0; flush = 1'b0;
        hold_ext = 1'b0; mem_done = 1'b0;
    endtask

    task automatic set_ex(input logic rd, input logic wr, input logic [15:0] alu,
                          input logic [15:0] wd);
        ex_valid = 1'b1; ex_memrd = rd; ex_memwrt = wr; ex_aluout = alu;
        ex_wrdata = wd; ex_regwrt = ~wr; ex_wrreg = 3'd5; ex_halt = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b0; ex_valid = 1'b1; ex_memrd = 1'b1; ex_aluout = 16'h0040; hold_ext = 1'b1;
        #1;
        nchk++;
        if ({ALUout, wrdata, MemRd, MemWrt, mem_valid, mem_regwrt, mem_halt, mem_wrreg, err} !== 41'd0) begin
            nfail++;
            $display("FAIL reset_outputs: got %h want 0",
                     {ALUout, wrdata, MemRd, MemWrt, mem_valid, mem_regwrt, mem_halt, mem_wrreg, err});
        end
        nchk++;
        if (stall_up !== 1'b1) begin nfail++; $display("FAIL reset_stall_hold1: got %b want 1", stall_up); end
        hold_ext = 1'b0;
        #1;
        nchk++;
        if (stall_up !== 1'b0) begin nfail++; $display("FAIL reset_stall_hold0: got %b want 0", stall_up); end
        tick();
        nchk++;
        if (MemRd !== 1'b0) begin nfail++; $display("FAIL reset_edge_memrd: got %b want 0", MemRd); end
        rst = 1'b1;
        tick();
        nchk++;
        if (MemRd !== 1'b1 || ALUout !== 16'h0040 || mem_valid !== 1'b1) begin
            nfail++;
            $display("FAIL reset_first_capture: got MemRd=%b ALUout=%h valid=%b want 1 0040 1",
                     MemRd, ALUout, mem_valid);
        end
        idle(); mem_done = 1'b1;
        #1;
        nchk++;
        if (stall_up !== 1'b0) begin nfail++; $display("FAIL reset_first_done_stall: got %b want 0", stall_up); end
        tick();
        mem_done = 1'b0;
    endtask

    task automatic test_load_hit();
        int req_cycles = 0;
        idle(); set_ex(1'b1, 1'b0, 16'h0040, 16'h0000);
        tick();
        set_ex(1'b0, 1'b0, 16'h1234, 16'h0000); mem_done = 1'b1;
        #1;
        if (MemRd === 1'b1) req_cycles++;
        nchk++;
        if (stall_up !== 1'b0 || ALUout !== 16'h0040) begin
            nfail++; $display("FAIL load_hit_req: got stall=%b ALUout=%h want 0 0040", stall_up, ALUout);
        end
        tick();
        idle();
        #1;
        if (MemRd === 1'b1) req_cycles++;
        nchk++;
        if (ALUout !== 16'h1234 || mem_valid !== 1'b1) begin
            nfail++; $display("FAIL load_hit_next: got ALUout=%h valid=%b want 1234 1", ALUout, mem_valid);
        end
        nchk++;
        if (req_cycles != 1) begin nfail++; $display("FAIL load_hit_memrd_cycles: got %0d want 1", req_cycles); end
        tick();
    endtask

    task automatic test_store_miss();
        int stalls = 0;
        int bad = 0;
        idle(); set_ex(1'b0, 1'b1, 16'h0102, 16'hBEEF);
        tick();
        set_ex(1'b0, 1'b0, 16'h5555, 16'h0000);
        for (int i = 1; i <= 4; i++) begin
            mem_done = (i == 4);
            #1;
            if (stall_up === 1'b1) stalls++;
            if (MemWrt !== 1'b1 || wrdata !== 16'hBEEF || ALUout !== 16'h0102) bad++;
            tick();
        end
        idle();
        #1;
        nchk++;
        if (bad != 0) begin nfail++; $display("FAIL store_miss_hold: got %0d bad cycles want 0", bad); end
        nchk++;
        if (stalls != 3) begin nfail++; $display("FAIL store_miss_stalls: got %0d want 3", stalls); end
        nchk++;
        if (MemWrt !== 1'b0 || ALUout !== 16'h5555) begin
            nfail++; $display("FAIL store_miss_next: got MemWrt=%b ALUout=%h want 0 5555", MemWrt, ALUout);
        end
        tick();
    endtask

    task automatic test_done_under_hold();
        int bad = 0;
        idle(); set_ex(1'b1, 1'b0, 16'h0200, 16'h0000);
        tick();
        set_ex(1'b0, 1'b0, 16'h7777, 16'h0000); mem_done = 1'b1; hold_ext = 1'b1;
        #1;
        nchk++;
        if (MemRd !== 1'b1 || stall_up !== 1'b1) begin
            nfail++; $display("FAIL hold_done_cycle: got MemRd=%b stall=%b want 1 1", MemRd, stall_up);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            mem_done = (i == 1);
            #1;
            if (MemRd !== 1'b0 || stall_up !== 1'b1 || ALUout !== 16'h0200) bad++;
            tick();
        end
        nchk++;
        if (bad != 0) begin nfail++; $display("FAIL hold_no_reissue: got %0d bad cycles want 0", bad); end
        hold_ext = 1'b0; mem_done = 1'b0;
        #1;
        nchk++;
        if (stall_up !== 1'b0) begin nfail++; $display("FAIL hold_release: got stall=%b want 0", stall_up); end
        tick();
        idle();
        #1;
        nchk++;
        if (ALUout !== 16'h7777 || MemRd !== 1'b0) begin
            nfail++; $display("FAIL hold_advance: got ALUout=%h MemRd=%b want 7777 0", ALUout, MemRd);
        end
        tick();
    endtask

    task automatic test_misaligned();
        idle(); set_ex(1'b0, 1'b1, 16'h0011, 16'hCAFE);
        tick();
        set_ex(1'b0, 1'b0, 16'h2222, 16'h0000);
        #1;
        nchk++;
        if (MemWrt !== 1'b0 || err !== 1'b1 || stall_up !== 1'b0) begin
            nfail++; $display("FAIL misaligned: got MemWrt=%b err=%b stall=%b want 0 1 0", MemWrt, err, stall_up);
        end
        tick();
        idle();
        #1;
        nchk++;
        if (err !== 1'b0 || ALUout !== 16'h2222) begin
            nfail++; $display("FAIL misaligned_clear: got err=%b ALUout=%h want 0 2222", err, ALUout);
        end
        tick();
    endtask

    task automatic test_flush();
        idle(); set_ex(1'b1, 1'b0, 16'h0300, 16'h0000); flush = 1'b1;
        tick();
        idle();
        #1;
        nchk++;
        if (mem_valid !== 1'b0 || MemRd !== 1'b0 || stall_up !== 1'b0 || mem_regwrt !== 1'b0) begin
            nfail++; $display("FAIL flush_advancing: got valid=%b MemRd=%b stall=%b want 0 0 0",
                              mem_valid, MemRd, stall_up);
        end
        set_ex(1'b1, 1'b0, 16'h0400, 16'h0000);
        tick();
        set_ex(1'b0, 1'b0, 16'h0999, 16'h0000); flush = 1'b1;
        tick();
        #1;
        nchk++;
        if (MemRd !== 1'b1 || mem_valid !== 1'b1 || ALUout !== 16'h0400) begin
            nfail++; $display("FAIL flush_stalled: got MemRd=%b valid=%b ALUout=%h want 1 1 0400",
                              MemRd, mem_valid, ALUout);
        end
        mem_done = 1'b1;
        tick();
        idle();
        #1;
        nchk++;
        if (mem_valid !== 1'b0 || ALUout !== 16'h0999) begin
            nfail++; $display("FAIL flush_held_capture: got valid=%b ALUout=%h want 0 0999", mem_valid, ALUout);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [15:0] addr [3];
        int bad = 0;
        addr[0] = 16'h0A00; addr[1] = 16'h0A02; addr[2] = 16'h0A04;
        idle(); set_ex(1'b1, 1'b0, addr[0], 16'h0000);
        tick();
        for (int i = 1; i <= 3; i++) begin
            if (i < 3) set_ex(1'b1, 1'b0, addr[i], 16'h0000);
            else idle();
            mem_done = 1'b1;
            #1;
            if (MemRd !== 1'b1 || ALUout !== addr[i-1] || stall_up !== 1'b0) bad++;
            tick();
        end
        mem_done = 1'b0;
        #1;
        nchk++;
        if (bad != 0) begin nfail++; $display("FAIL back_to_back: got %0d gap/addr errors want 0", bad); end
        nchk++;
        if (MemRd !== 1'b0) begin nfail++; $display("FAIL back_to_back_end: got MemRd=%b want 0", MemRd); end
        tick();
    endtask

    task automatic test_reset_mid_req();
        idle(); set_ex(1'b1, 1'b0, 16'h0600, 16'h0000);
        tick();
        idle();
        #1;
        rst = 1'b0;
        #1;
        nchk++;
        if (MemRd !== 1'b0 || mem_valid !== 1'b0 || ALUout !== 16'h0000) begin
            nfail++; $display("FAIL reset_mid_req: got MemRd=%b valid=%b ALUout=%h want 0 0 0000",
                              MemRd, mem_valid, ALUout);
        end
        rst = 1'b1;
        tick();
        #1;
        nchk++;
        if (MemRd !== 1'b0 || stall_up !== 1'b0) begin
            nfail++; $display("FAIL reset_mid_req_lost: got MemRd=%b stall=%b want 0 0", MemRd, stall_up);
        end
    endtask

`ifdef EXMEM_TIMEOUT_EN
    task automatic test_timeout();
        int bad = 0;
        idle(); set_ex(1'b1, 1'b0, 16'h0500, 16'h0000);
        tick();
        set_ex(1'b0, 1'b0, 16'h3333, 16'h0000);
        for (int i = 0; i < TO; i++) begin
            #1;
            if (MemRd !== 1'b1 || stall_up !== 1'b1 || err !== 1'b0) bad++;
            tick();
        end
        #1;
        nchk++;
        if (bad != 0) begin nfail++; $display("FAIL timeout_wait: got %0d bad cycles want 0", bad); end
        nchk++;
        if (MemRd !== 1'b0 || err !== 1'b1 || stall_up !== 1'b0 || mem_regwrt !== 1'b0 || mem_valid !== 1'b1) begin
            nfail++; $display("FAIL timeout_abort: got MemRd=%b err=%b stall=%b regwrt=%b valid=%b want 0 1 0 0 1",
                              MemRd, err, stall_up, mem_regwrt, mem_valid);
        end
        tick();
        idle();
        #1;
        nchk++;
        if (err !== 1'b0 || ALUout !== 16'h3333) begin
            nfail++; $display("FAIL timeout_clear: got err=%b ALUout=%h want 0 3333", err, ALUout);
        end
        tick();
    endtask
`endif

    typedef struct packed {
        logic        v;
        logic        rd;
        logic        wr;
        logic        rw;
        logic        halt;
        logic [2:0]  wrreg;
        logic [15:0] alu;
        logic [15:0] wd;
    } ent_t;

    // Model: the entry in flight, whether its access is still owed, and its age.
    task automatic test_random(input int ncyc);
        ent_t        m;
        logic        m_pend;
        logic        m_err;
        int          m_age;
        logic        need_new;
        logic        exp_stall;
        logic        cap;
        logic [41:0] exp_v;
        logic [41:0] act_v;
        int          kind;
        int          bad = 0;
        idle();
        rst = 1'b0;
        #1;
        rst = 1'b1;
        m = '0; m_pend = 1'b0; m_err = 1'b0; m_age = 0; need_new = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            if (need_new) begin
                kind      = int'($urandom_range(0, 2));
                ex_valid  = ($urandom_range(0, 3) != 0);
                ex_memrd  = (kind == 1);
                ex_memwrt = (kind == 2);
                ex_aluout = 16'($urandom);
                if ($urandom_range(0, 3) != 0) ex_aluout[0] = 1'b0;
                ex_wrdata = 16'($urandom);
                ex_regwrt = (kind != 2) && ($urandom_range(0, 1) == 1);
                ex_wrreg  = 3'($urandom);
                ex_halt   = ($urandom_range(0, 15) == 0);
                flush     = ($urandom_range(0, 7) == 0);
            end
            hold_ext = ($urandom_range(0, 4) == 0);
            mem_done = ($urandom_range(0, 9) < 4);
            #1;
            exp_stall = hold_ext | (m_pend & ~mem_done);
            exp_v = {m.alu, m.wd, m_pend & m.rd, m_pend & m.wr, m.v, m.rw, m.halt, m.wrreg, m_err, exp_stall};
            act_v = {ALUout, wrdata, MemRd, MemWrt, mem_valid, mem_regwrt, mem_halt, mem_wrreg, err, stall_up};
            nchk++;
            if (act_v !== exp_v) begin
                nfail++; bad++;
                if (bad <= 10) $display("FAIL random_cycle_%0d: got %h want %h", c, act_v, exp_v);
            end
            if (!exp_stall) begin
                cap     = ex_valid & ~flush;
                m.v     = cap;
                m.rd    = cap & ex_memrd;
                m.wr    = cap & ex_memwrt;
                m.rw    = cap & ex_regwrt;
                m.halt  = cap & ex_halt;
                m.wrreg = ex_wrreg;
                m.alu   = ex_aluout;
                m.wd    = ex_wrdata;
                m_pend  = cap & (ex_memrd | ex_memwrt) & ~ex_aluout[0];
                m_err   = cap & (ex_memrd | ex_memwrt) &  ex_aluout[0];
                m_age   = 0;
            end else if (m_pend && mem_done) begin
                m_pend = 1'b0;
            end else if (m_pend) begin
                m_age++;
`ifdef EXMEM_TIMEOUT_EN
                if (m_age == TO) begin
                    m_pend = 1'b0; m_err = 1'b1; m.rw = 1'b0;
                end
`endif
            end
            need_new = ~exp_stall;
            tick();
        end
        idle(); mem_done = 1'b1;
        tick();
        idle();
        tick();
    endtask

    initial begin
        idle();
        rst = 1'b0;
        test_reset();
        test_load_hit();
        test_store_miss();
        test_done_under_hold();
        test_misaligned();
        test_flush();
        test_back_to_back();
`ifdef EXMEM_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_req();
        test_random(400);
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
`default_nettype wire
